bp_cce_dir_sharers_collect: RTL and testbench

- Directory read-out stage directly upstream of the CCE GAD op.
- On a directory-read command it sweeps every row of one way-group in the coherence directory RAM and tag-compares each entry against the target tag.
- It consolidates the results into per-LCE hit, way and coherence-state vectors, then asserts sharers_v_o.
- The vectors are held until the next command, so GAD consumes them as level inputs.

---
 rtl/bp_cce_pkg.sv | 32 +++
 rtl/bp_cce_dir_row_match.sv | 36 +++
 rtl/bp_cce_dir_sharers_collect.sv | 180 ++++++++++++++++++
 tb/tb_bp_cce_dir_sharers_collect.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_cce_pkg.sv
// rtl/bp_cce_pkg.sv - coherence states, directory entry layout and sweep FSM states for the CCE directory read-out
package bp_cce_pkg;

  typedef enum logic [2:0] {
    e_COH_I = 3'b000,
    e_COH_S = 3'b001,
    e_COH_E = 3'b010,
    e_COH_F = 3'b011,
    e_COH_B = 3'b100,
    e_COH_M = 3'b110,
    e_COH_O = 3'b111
  } bp_coh_states_e;

  localparam int dir_tag_width_gp = 20;

  typedef struct packed {
    logic [dir_tag_width_gp-1:0] tag;
    bp_coh_states_e              state;
  } bp_cce_dir_entry_s;

  typedef enum logic [1:0] {
    e_IDLE,
    e_READ,
    e_DRAIN,
    e_DONE
  } bp_cce_sharers_state_e;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_cce_dir_row_match.sv
// rtl/bp_cce_dir_row_match.sv - tag-compares one directory row, reporting per-entry hits, lowest hit offset/state and multi-hit
module bp_cce_dir_row_match
  import bp_cce_pkg::*;
#(
  parameter int entries_per_row_p = 2,
  parameter int tag_width_p       = 20,
  localparam int entry_width_lp   = tag_width_p + 3,
  localparam int off_width_lp     = safe_clog2(entries_per_row_p)
) (
  input  logic [entries_per_row_p*entry_width_lp-1:0] row_i,
  input  logic [tag_width_p-1:0]                      tag_i,
  output logic [entries_per_row_p-1:0]                hits_o,
  output logic                                        multi_hit_o,
  output logic [off_width_lp-1:0]                     way_off_o,
  output logic [2:0]                                  state_o
);

  always_comb begin
    hits_o    = '0;
    way_off_o = '0;
    state_o   = 3'(e_COH_I);
    for (int i = 0; i < entries_per_row_p; i++) begin
      hits_o[i] = (row_i[i*entry_width_lp+3 +: tag_width_p] == tag_i)
               && (row_i[i*entry_width_lp +: 3] != 3'(e_COH_I));
    end
    // Walk downward so the lowest hitting way is the one left standing.
    for (int i = entries_per_row_p-1; i >= 0; i--) begin
      if (hits_o[i]) begin
        way_off_o = off_width_lp'(i);
        state_o   = row_i[i*entry_width_lp +: 3];
      end
    end
    multi_hit_o = (hits_o & (hits_o - entries_per_row_p'(1))) != '0;
  end

endmodule

// File: rtl/bp_cce_dir_sharers_collect.sv
// rtl/bp_cce_dir_sharers_collect.sv - sweeps one directory way-group and builds per-LCE sharer vectors; BP_CCE_SHARERS_LRU_CAPTURE_EN adds LRU entry capture
module bp_cce_dir_sharers_collect
  import bp_cce_pkg::*;
#(
  parameter int num_lce_p         = 4,
  parameter int lce_assoc_p       = 4,
  parameter int entries_per_row_p = 2,
  parameter int tag_width_p       = 20,
  parameter int way_group_width_p = 6,
  localparam int lce_assoc_width_lp = $clog2(lce_assoc_p),
  localparam int lce_id_width_lp    = safe_clog2(num_lce_p),
  localparam int rows_per_lce_lp    = lce_assoc_p / entries_per_row_p,
  localparam int num_rows_lp        = num_lce_p * rows_per_lce_lp,
  localparam int row_width_lp       = safe_clog2(num_rows_lp),
  localparam int entry_width_lp     = tag_width_p + 3,
  localparam int off_width_lp       = safe_clog2(entries_per_row_p)
) (
  input  logic                                        clk_i,
  input  logic                                        reset_n_i,
  input  logic                                        start_v_i,
  output logic                                        ready_o,
  input  logic [tag_width_p-1:0]                      tag_i,
  input  logic [way_group_width_p-1:0]                way_group_i,
`ifdef BP_CCE_SHARERS_LRU_CAPTURE_EN
  input  logic [lce_id_width_lp-1:0]                  req_lce_i,
  input  logic [lce_assoc_width_lp-1:0]               lru_way_i,
  output logic [2:0]                                  lru_coh_state_o,
  output logic [tag_width_p-1:0]                      lru_tag_o,
`endif
  output logic                                        dir_r_v_o,
  output logic [way_group_width_p+row_width_lp-1:0]   dir_addr_o,
  input  logic [entries_per_row_p*entry_width_lp-1:0] dir_data_i,
  output logic                                        sharers_v_o,
  output logic [num_lce_p-1:0]                        sharers_hits_o,
  output logic [num_lce_p*lce_assoc_width_lp-1:0]     sharers_ways_o,
  output logic [num_lce_p*3-1:0]                      sharers_coh_states_o,
  output logic                                        multi_hit_o
);

  bp_cce_sharers_state_e            state_r;
  logic [tag_width_p-1:0]           tag_r;
  logic [way_group_width_p-1:0]     wg_r;
  logic [row_width_lp-1:0]          row_r;
  logic [lce_id_width_lp-1:0]       lce_r;
  logic [lce_assoc_width_lp-1:0]    way_base_r;
  logic                             pipe_v_r;
  logic [lce_id_width_lp-1:0]       pipe_lce_r;
  logic [lce_assoc_width_lp-1:0]    pipe_way_base_r;

  logic [entries_per_row_p-1:0]     match_hits;
  logic                             match_multi;
  logic [off_width_lp-1:0]          match_off;
  logic [2:0]                       match_state;
  logic [lce_assoc_width_lp-1:0]    match_way;
  logic                             accept, last_row, last_blk;

  assign dir_addr_o = {wg_r, row_r};
  assign accept     = start_v_i && (state_r == e_IDLE || state_r == e_DONE);
  assign last_row   = row_r == row_width_lp'(num_rows_lp-1);
  assign last_blk   = way_base_r == lce_assoc_width_lp'(lce_assoc_p-entries_per_row_p);
  assign match_way  = pipe_way_base_r + lce_assoc_width_lp'(match_off);

  bp_cce_dir_row_match #(
    .entries_per_row_p(entries_per_row_p),
    .tag_width_p      (tag_width_p)
  ) row_match (
    .row_i      (dir_data_i),
    .tag_i      (tag_r),
    .hits_o     (match_hits),
    .multi_hit_o(match_multi),
    .way_off_o  (match_off),
    .state_o    (match_state)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r              <= e_IDLE;
      ready_o              <= 1'b1;
      dir_r_v_o            <= 1'b0;
      sharers_v_o          <= 1'b0;
      sharers_hits_o       <= '0;
      sharers_ways_o       <= '0;
      sharers_coh_states_o <= {num_lce_p{3'(e_COH_I)}};
      multi_hit_o          <= 1'b0;
      tag_r                <= '0;
      wg_r                 <= '0;
      row_r                <= '0;
      lce_r                <= '0;
      way_base_r           <= '0;
      pipe_v_r             <= 1'b0;
      pipe_lce_r           <= '0;
      pipe_way_base_r      <= '0;
    end else begin
      // RAM data lags the strobe by one cycle; carry the row's owner alongside it.
      pipe_v_r        <= dir_r_v_o;
      pipe_lce_r      <= lce_r;
      pipe_way_base_r <= way_base_r;
      case (state_r)
        e_IDLE, e_DONE: begin
          if (accept) begin
            state_r              <= e_READ;
            ready_o              <= 1'b0;
            dir_r_v_o            <= 1'b1;
            sharers_v_o          <= 1'b0;
            tag_r                <= tag_i;
            wg_r                 <= way_group_i;
            row_r                <= '0;
            lce_r                <= '0;
            way_base_r           <= '0;
            sharers_hits_o       <= '0;
            sharers_ways_o       <= '0;
            sharers_coh_states_o <= {num_lce_p{3'(e_COH_I)}};
            multi_hit_o          <= 1'b0;
          end
        end
        e_READ: begin
          if (last_row) begin
            state_r   <= e_DRAIN;
            dir_r_v_o <= 1'b0;
          end else begin
            row_r <= row_r + row_width_lp'(1);
            if (last_blk) begin
              way_base_r <= '0;
              lce_r      <= lce_r + lce_id_width_lp'(1);
            end else begin
              way_base_r <= way_base_r + lce_assoc_width_lp'(entries_per_row_p);
            end
          end
        end
        e_DRAIN: begin
          state_r     <= e_DONE;
          sharers_v_o <= 1'b1;
          ready_o     <= 1'b1;
        end
        default: state_r <= e_IDLE;
      endcase
      if (pipe_v_r && (|match_hits)) begin
        if (sharers_hits_o[pipe_lce_r]) begin
          multi_hit_o <= 1'b1;
        end else begin
          sharers_hits_o[pipe_lce_r]                                             <= 1'b1;
          sharers_ways_o[int'(pipe_lce_r)*lce_assoc_width_lp +: lce_assoc_width_lp] <= match_way;
          sharers_coh_states_o[int'(pipe_lce_r)*3 +: 3]                          <= match_state;
          if (match_multi) multi_hit_o <= 1'b1;
        end
      end
    end
  end

`ifdef BP_CCE_SHARERS_LRU_CAPTURE_EN
  logic [lce_id_width_lp-1:0]    req_lce_r;
  logic [lce_assoc_width_lp-1:0] lru_way_r;
  logic [lce_assoc_width_lp-1:0] lru_diff;
  logic                          lru_in_row;
  logic [entry_width_lp-1:0]     lru_entry;

  // The LRU way lies in the current row when its distance from the row's way base is below the row width.
  assign lru_diff   = lru_way_r - pipe_way_base_r;
  assign lru_in_row = {1'b0, lru_diff} < (lce_assoc_width_lp+1)'(entries_per_row_p);
  assign lru_entry  = dir_data_i[int'(lru_diff[off_width_lp-1:0])*entry_width_lp +: entry_width_lp];

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      req_lce_r       <= '0;
      lru_way_r       <= '0;
      lru_coh_state_o <= 3'(e_COH_I);
      lru_tag_o       <= '0;
    end else if (accept) begin
      req_lce_r       <= req_lce_i;
      lru_way_r       <= lru_way_i;
      lru_coh_state_o <= 3'(e_COH_I);
      lru_tag_o       <= '0;
    end else if (pipe_v_r && pipe_lce_r == req_lce_r && lru_in_row) begin
      lru_coh_state_o <= lru_entry[2:0];
      lru_tag_o       <= lru_entry[entry_width_lp-1:3];
    end
  end
`endif

endmodule

// File: tb/tb_bp_cce_dir_sharers_collect.sv
// tb/tb_bp_cce_dir_sharers_collect.sv - randomized bench for the directory sharers collector against a per-LCE scan model
module tb_bp_cce_dir_sharers_collect;
  import bp_cce_pkg::*;

  localparam int N = 4, A = 4, E = 2, TW = 20, WGW = 6, AW = 2, RW = 3, EW = TW + 3;
  localparam int ROWS = 8, RPL = A / E, DONE_PH = ROWS + 2;

  logic              clk;
  logic              reset_n_i;
  logic              start_v_i;
  logic              ready_o;
  logic [TW-1:0]     tag_i;
  logic [WGW-1:0]    way_group_i;
  logic              dir_r_v_o;
  logic [WGW+RW-1:0] dir_addr_o;
  logic [E*EW-1:0]   dir_data_i;
  logic              sharers_v_o;
  logic [N-1:0]      sharers_hits_o;
  logic [N*AW-1:0]   sharers_ways_o;
  logic [N*3-1:0]    sharers_coh_states_o;
  logic              multi_hit_o;
`ifdef BP_CCE_SHARERS_LRU_CAPTURE_EN
  logic [1:0]        req_lce_i;
  logic [AW-1:0]     lru_way_i;
  logic [2:0]        lru_coh_state_o;
  logic [TW-1:0]     lru_tag_o;
  logic [2:0]        exp_lru_st;
  logic [TW-1:0]     exp_lru_tag;
`endif

  bp_cce_dir_sharers_collect dut (
    .clk_i               (clk),
    .reset_n_i           (reset_n_i),
    .start_v_i           (start_v_i),
    .ready_o             (ready_o),
    .tag_i               (tag_i),
    .way_group_i         (way_group_i),
`ifdef BP_CCE_SHARERS_LRU_CAPTURE_EN
    .req_lce_i           (req_lce_i),
    .lru_way_i           (lru_way_i),
    .lru_coh_state_o     (lru_coh_state_o),
    .lru_tag_o           (lru_tag_o),
`endif
    .dir_r_v_o           (dir_r_v_o),
    .dir_addr_o          (dir_addr_o),
    .dir_data_i          (dir_data_i),
    .sharers_v_o         (sharers_v_o),
    .sharers_hits_o      (sharers_hits_o),
    .sharers_ways_o      (sharers_ways_o),
    .sharers_coh_states_o(sharers_coh_states_o),
    .multi_hit_o         (multi_hit_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directory contents as the spec describes them: way-group -> LCE -> way.
  logic [TW-1:0] m_tag [64][N][A];
  logic [2:0]    m_st  [64][N][A];

  logic [N-1:0]    exp_hits;
  logic [N*AW-1:0] exp_ways;
  logic [N*3-1:0]  exp_states;
  logic            exp_multi;
  logic [WGW-1:0]  exp_wg;
  int              phase;
  bit              chk_reset;
  int              checks, errors;
  int              cmd_req, cmd_lru;

  // Directory RAM: one-cycle read latency; garbage on idle cycles must be ignored.
  logic [E*EW-1:0] ram_row;
  int              ram_r, ram_wg;
  always @(posedge clk) begin
    if (dir_r_v_o) begin
      ram_r  = int'(dir_addr_o[RW-1:0]);
      ram_wg = int'(dir_addr_o[RW +: WGW]);
      for (int e = 0; e < E; e++)
        ram_row[e*EW +: EW] = {m_tag[ram_wg][ram_r/RPL][(ram_r%RPL)*E+e], m_st[ram_wg][ram_r/RPL][(ram_r%RPL)*E+e]};
      dir_data_i <= ram_row;
    end else begin
      dir_data_i <= (E*EW)'({$urandom, $urandom});
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (phase %0d)", name, act, exp, phase);
    end
  endtask

  task automatic model(input logic [TW-1:0] t, input int wg);
    bit found;
    exp_hits = '0; exp_ways = '0; exp_states = '0; exp_multi = 1'b0;
    for (int l = 0; l < N; l++) begin
      found = 1'b0;
      for (int w = 0; w < A; w++) begin
        if (m_tag[wg][l][w] == t && m_st[wg][l][w] != 3'(e_COH_I)) begin
          if (found) exp_multi = 1'b1;
          else begin
            found = 1'b1;
            exp_hits[l] = 1'b1;
            exp_ways[l*AW +: AW] = AW'(w);
            exp_states[l*3 +: 3] = m_st[wg][l][w];
          end
        end
      end
    end
`ifdef BP_CCE_SHARERS_LRU_CAPTURE_EN
    exp_lru_st  = m_st[wg][cmd_req][cmd_lru];
    exp_lru_tag = m_tag[wg][cmd_req][cmd_lru];
`endif
  endtask

  always @(negedge clk) begin
    if (chk_reset) begin
      chk("rst_ready", 64'(ready_o), 64'd1);
      chk("rst_dir_r_v", 64'(dir_r_v_o), 64'd0);
      chk("rst_sharers_v", 64'(sharers_v_o), 64'd0);
      chk("rst_hits", 64'(sharers_hits_o), 64'd0);
      chk("rst_ways", 64'(sharers_ways_o), 64'd0);
      chk("rst_states", 64'(sharers_coh_states_o), 64'd0);
      chk("rst_multi", 64'(multi_hit_o), 64'd0);
`ifdef BP_CCE_SHARERS_LRU_CAPTURE_EN
      chk("rst_lru_state", 64'(lru_coh_state_o), 64'd0);
      chk("rst_lru_tag", 64'(lru_tag_o), 64'd0);
`endif
    end else if (phase == 0) begin
      chk("ready_at_accept", 64'(ready_o), 64'd1);
    end else if (phase >= 1) begin
      chk("dir_r_v", 64'(dir_r_v_o), 64'(phase <= ROWS));
      if (phase <= ROWS) chk("dir_addr", 64'(dir_addr_o), 64'({exp_wg, RW'(phase-1)}));
      chk("ready", 64'(ready_o), 64'(phase >= DONE_PH));
      chk("sharers_v", 64'(sharers_v_o), 64'(phase >= DONE_PH));
      if (phase >= DONE_PH) begin
        chk("hits", 64'(sharers_hits_o), 64'(exp_hits));
        chk("ways", 64'(sharers_ways_o), 64'(exp_ways));
        chk("states", 64'(sharers_coh_states_o), 64'(exp_states));
        chk("multi_hit", 64'(multi_hit_o), 64'(exp_multi));
`ifdef BP_CCE_SHARERS_LRU_CAPTURE_EN
        chk("lru_state", 64'(lru_coh_state_o), 64'(exp_lru_st));
        chk("lru_tag", 64'(lru_tag_o), 64'(exp_lru_tag));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (phase >= 0) phase++;
  endtask

  task automatic launch(input logic [TW-1:0] t, input int wg);
    model(t, wg);
    exp_wg      = WGW'(wg);
    start_v_i   = 1'b1;
    tag_i       = t;
    way_group_i = WGW'(wg);
`ifdef BP_CCE_SHARERS_LRU_CAPTURE_EN
    req_lce_i = 2'(cmd_req);
    lru_way_i = AW'(cmd_lru);
`endif
    phase = 0;
    tick();
  endtask

  // Busy-time start pulses carry random operands and must be ignored.
  task automatic busy_cycle();
    if (phase >= 1 && phase <= ROWS + 1 && $urandom_range(0, 2) == 0) begin
      start_v_i   = 1'b1;
      tag_i       = TW'($urandom);
      way_group_i = WGW'($urandom);
`ifdef BP_CCE_SHARERS_LRU_CAPTURE_EN
      req_lce_i = 2'($urandom);
      lru_way_i = AW'($urandom);
`endif
    end else begin
      start_v_i = 1'b0;
    end
    tick();
  endtask

  task automatic issue(input logic [TW-1:0] t, input int wg);
    launch(t, wg);
    while (phase < DONE_PH + 2) busy_cycle();
  endtask

  task automatic fill(input int wg, input logic [TW-1:0] t);
    logic [2:0] st_pick [7];
    st_pick = '{3'(e_COH_I), 3'(e_COH_S), 3'(e_COH_E), 3'(e_COH_F), 3'(e_COH_B), 3'(e_COH_M), 3'(e_COH_O)};
    for (int l = 0; l < N; l++)
      for (int w = 0; w < A; w++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: m_tag[wg][l][w] = t;
          4, 5:       m_tag[wg][l][w] = t ^ TW'(1);
          default:    m_tag[wg][l][w] = TW'($urandom);
        endcase
        m_st[wg][l][w] = ($urandom_range(0, 2) == 0) ? 3'(e_COH_I) : st_pick[$urandom_range(0, 6)];
      end
  endtask

  initial begin
    logic [TW-1:0] t;
    int            wg;
    checks = 0; errors = 0; phase = -1; chk_reset = 1'b0;
    cmd_req = 0; cmd_lru = 0;
    reset_n_i = 1'b0; start_v_i = 1'b0; tag_i = '0; way_group_i = '0;
`ifdef BP_CCE_SHARERS_LRU_CAPTURE_EN
    req_lce_i = '0; lru_way_i = '0;
`endif
    for (int g = 0; g < 64; g++)
      for (int l = 0; l < N; l++)
        for (int w = 0; w < A; w++) begin
          m_tag[g][l][w] = 20'h00ABC;
          m_st[g][l][w]  = 3'(e_COH_I);
        end
    repeat (2) tick();
    chk_reset = 1'b1;
    tick();
    reset_n_i = 1'b1;
    tick();
    chk_reset = 1'b0;

    // Empty directory: tag matches everywhere but every entry is invalid.
    issue(20'h00ABC, 5);
    chk("pin_empty_hits", 64'(exp_hits), 64'h0);
    chk("pin_empty_states", 64'(exp_states), 64'h0);

    m_st[5][2][3] = 3'(e_COH_M);
    m_st[5][0][1] = 3'(e_COH_S);
    m_tag[5][1][0] = 20'h00ABD; m_st[5][1][0] = 3'(e_COH_E);
    issue(20'h00ABC, 5);
    chk("pin_two_hits", 64'(exp_hits), 64'b0101);
    chk("pin_two_ways", 64'(exp_ways), 64'h31);
    chk("pin_two_states", 64'(exp_states), 64'h181);
    chk("pin_two_multi", 64'(exp_multi), 64'd0);

    m_st[5][3][0] = 3'(e_COH_S);
    m_st[5][3][2] = 3'(e_COH_S);
    cmd_req = 1; cmd_lru = 2;
    m_tag[5][1][2] = 20'h12345; m_st[5][1][2] = 3'(e_COH_E);
    issue(20'h00ABC, 5);
    chk("pin_multi_hits", 64'(exp_hits), 64'b1101);
    chk("pin_multi_way3", 64'(exp_ways[3*AW +: AW]), 64'd0);
    chk("pin_multi_flag", 64'(exp_multi), 64'd1);
`ifdef BP_CCE_SHARERS_LRU_CAPTURE_EN
    chk("pin_lru_state", 64'(exp_lru_st), 64'(e_COH_E));
    chk("pin_lru_tag", 64'(exp_lru_tag), 64'h12345);
`endif

    // Reset while row 4 is being read; the sweep is abandoned.
    fill(9, 20'h5A5A5);
    launch(20'h5A5A5, 9);
    while (phase < 5) busy_cycle();
    start_v_i = 1'b0;
    reset_n_i = 1'b0;
    phase = -1;
    tick();
    reset_n_i = 1'b1;
    chk_reset = 1'b1;
    tick();
    chk_reset = 1'b0;
    issue(20'h5A5A5, 9);

    for (int n = 0; n < 40; n++) begin
      t  = TW'($urandom);
      wg = $urandom_range(0, 63);
      cmd_req = $urandom_range(0, N-1);
      cmd_lru = $urandom_range(0, A-1);
      fill(wg, t);
      issue(t, wg);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
